// File: rtl/thcattus_keypad_pkg.sv
// Shared types and helpers for the matrix-keypad scanner.
// The optional auto-repeat feature is enabled by THCATTUS_KEYPAD_AUTOREPEAT_EN.
package thcattus_keypad_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDebPress,
    StHeld,
    StDebRel
  } kp_state_e;

  // Frame results carry a found flag beside the code; found == KeyNone means no key.
  localparam logic KeyNone = 1'b0;

  function automatic int unsigned code_width(int unsigned rows, int unsigned cols);
    return $clog2(rows * cols);
  endfunction

endpackage

// File: rtl/thcattus_keypad_scanner_if.sv
// Key-event stream from the keypad scanner to control logic (valid/ready).
interface thcattus_keypad_scanner_if #(
  parameter int unsigned CODE_W = 4
) ();
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_ready;
  logic              key_pressed;

  modport master (
    output key_code,
    output key_valid,
    output key_pressed,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_pressed,
    output key_ready
  );
endinterface

// File: rtl/thcattus_keypad_scan_timer.sv
// Column period divider and active-low one-hot column strobe generator.
module thcattus_keypad_scan_timer #(
  parameter int unsigned COLS = 4,
  parameter int unsigned DIV  = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    tick,
  output logic [$clog2(COLS)-1:0] col_idx,
  output logic                    frame_end,
  output logic [COLS-1:0]         col
);
  localparam int unsigned DivW = $clog2(DIV);
  localparam int unsigned ColW = $clog2(COLS);

  logic [DivW-1:0] div_q, div_d;
  logic [ColW-1:0] idx_q, idx_d;
  logic [COLS-1:0] col_q, col_d;

  assign tick      = (div_q == DivW'(DIV - 1));
  assign frame_end = tick && (idx_q == ColW'(COLS - 1));
  assign col_idx   = idx_q;
  assign col       = col_q;

  always_comb begin
    div_d = div_q + DivW'(1);
    idx_d = idx_q;
    col_d = col_q;
    if (tick) begin
      div_d = '0;
      idx_d = (idx_q == ColW'(COLS - 1)) ? '0 : idx_q + ColW'(1);
      // Rotating the single low bit keeps exactly one column driven.
      col_d = {col_q[COLS-2:0], col_q[COLS-1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      idx_q <= '0;
      col_q <= ~COLS'(1);
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      col_q <= col_d;
    end
  end
endmodule

// File: rtl/thcattus_keypad_scanner.sv
// Matrix keypad scanner: frame-based debounce FSM and one-event-per-press handshake.
// Define THCATTUS_KEYPAD_AUTOREPEAT_EN to re-emit held keys every REPEAT_FRAMES frames.
module thcattus_keypad_scanner
  import thcattus_keypad_pkg::*;
#(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned CLOCK_FREQ     = 25_000_000,
  parameter int unsigned SCAN_RATE      = 1_000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_FRAMES  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [COLS-1:0]           col,
  input  logic [ROWS-1:0]           row,
  thcattus_keypad_scanner_if.master kp
);
  localparam int unsigned Div   = CLOCK_FREQ / SCAN_RATE;
  localparam int unsigned CodeW = code_width(ROWS, COLS);
  localparam int unsigned ColW  = $clog2(COLS);
  localparam int unsigned CntW  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_SCANS - 1);

  logic            tick, frame_end;
  logic [ColW-1:0] col_idx;
  logic [ROWS-1:0] row_s1_q, row_s2_q;

  thcattus_keypad_scan_timer #(
    .COLS (COLS),
    .DIV  (Div)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .col_idx   (col_idx),
    .frame_end (frame_end),
    .col       (col)
  );

  // Lowest low row in the current column; lower row wins.
  logic             cur_found;
  logic [CodeW-1:0] cur_code;
  always_comb begin
    cur_found = KeyNone;
    cur_code  = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!row_s2_q[r]) begin
        cur_found = 1'b1;
        cur_code  = CodeW'(int'(col_idx) * int'(ROWS) + r);
      end
    end
  end

  // Earlier columns win, so an accumulated hit is never replaced within a frame.
  logic             acc_found_q, frame_found;
  logic [CodeW-1:0] acc_code_q, frame_code;
  assign frame_found = acc_found_q | cur_found;
  assign frame_code  = acc_found_q ? acc_code_q : cur_code;

  kp_state_e        state_q, state_d;
  logic [CodeW-1:0] cand_q, cand_d, emit_code, code_q, code_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             pressed_q, pressed_d, valid_q, valid_d, emit;
`ifdef THCATTUS_KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_FRAMES + 1);
  logic [RepW-1:0] rep_q, rep_d;
`endif

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    emit      = 1'b0;
    emit_code = cand_q;
`ifdef THCATTUS_KEYPAD_AUTOREPEAT_EN
    rep_d     = rep_q;
`endif
    if (frame_end) begin
      unique case (state_q)
        StIdle: begin
          if (frame_found) begin
            cand_d    = frame_code;
            emit_code = frame_code;
            if (DEBOUNCE_SCANS == 1) begin
              state_d   = StHeld;
              pressed_d = 1'b1;
              emit      = 1'b1;
            end else begin
              state_d = StDebPress;
              cnt_d   = CntW'(1);
            end
          end
        end
        StDebPress: begin
          if (frame_found && frame_code == cand_q) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == DebLast) begin
              state_d   = StHeld;
              pressed_d = 1'b1;
              emit      = 1'b1;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StHeld: begin
          if (!frame_found) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d   = StIdle;
              pressed_d = 1'b0;
            end else begin
              state_d = StDebRel;
              cnt_d   = CntW'(1);
            end
          end
`ifdef THCATTUS_KEYPAD_AUTOREPEAT_EN
          else begin
            rep_d = rep_q + RepW'(1);
            if (rep_q == RepW'(REPEAT_FRAMES - 1)) begin
              rep_d = '0;
              emit  = 1'b1;
            end
          end
`endif
        end
        StDebRel: begin
          if (frame_found) begin
            state_d = StHeld;
          end else begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == DebLast) begin
              state_d   = StIdle;
              pressed_d = 1'b0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
`ifdef THCATTUS_KEYPAD_AUTOREPEAT_EN
    if (state_q != StHeld || state_d != StHeld) rep_d = '0;
`endif
  end

  // A pending event blocks new ones unless it is being accepted on this edge.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    if (emit && (!valid_q || kp.key_ready)) begin
      valid_d = 1'b1;
      code_d  = emit_code;
    end else if (valid_q && kp.key_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1_q    <= '1;
      row_s2_q    <= '1;
      acc_found_q <= KeyNone;
      acc_code_q  <= '0;
      state_q     <= StIdle;
      cand_q      <= '0;
      cnt_q       <= '0;
      pressed_q   <= 1'b0;
      valid_q     <= 1'b0;
      code_q      <= '0;
`ifdef THCATTUS_KEYPAD_AUTOREPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      row_s1_q  <= row;
      row_s2_q  <= row_s1_q;
      if (tick) begin
        acc_found_q <= frame_end ? KeyNone : frame_found;
        acc_code_q  <= frame_end ? '0 : frame_code;
      end
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
`ifdef THCATTUS_KEYPAD_AUTOREPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign kp.key_code    = code_q;
  assign kp.key_valid   = valid_q;
  assign kp.key_pressed = pressed_q;
endmodule

// File: tb/tb_thcattus_keypad_scanner.sv
// Self-checking bench: table of key patterns plus hand sequences, with an event scoreboard.
module tb_thcattus_keypad_scanner;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] keys = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int ev_count = 0;
  logic [3:0] exp_q[$];

  thcattus_keypad_scanner_if #(.CODE_W(4)) kp_if ();

  thcattus_keypad_scanner #(
    .ROWS           (4),
    .COLS           (4),
    .CLOCK_FREQ     (1000),
    .SCAN_RATE      (100),
    .DEBOUNCE_SCANS (2),
    .REPEAT_FRAMES  (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .col   (col),
    .row   (row),
    .kp    (kp_if)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted transfer must match the oldest expected code.
  always @(negedge clk) begin
    if (!reset && kp_if.key_valid === 1'b1 && kp_if.key_ready === 1'b1) begin
      ev_count++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got code %0d expected no event", kp_if.key_code);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (kp_if.key_code !== e) begin
          n_fail++;
          $display("FAIL event_code: got %0d expected %0d", kp_if.key_code, e);
        end
      end
    end
  end

  task automatic wait_frame_end(output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    prev = col;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (prev == 4'b0111 && col == 4'b1110) begin
        ok = 1'b1;
        break;
      end
      prev = col;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_timeout: got no frame end expected one within 100 clk");
    end
  endtask

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
    string       name;
  } vec_t;

  vec_t vecs[7];
  logic [3:0] seq[4];

  initial begin
    bit ok;
    int saved;
    vecs[0] = '{16'h0200, 4'd9,  "single_9"};
    vecs[1] = '{16'h2040, 4'd6,  "chord_6_13"};
    vecs[2] = '{16'h0001, 4'd0,  "single_0"};
    vecs[3] = '{16'h8000, 4'd15, "single_15"};
    vecs[4] = '{16'h0008, 4'd3,  "single_3"};
    vecs[5] = '{16'h1008, 4'd3,  "chord_3_12"};
    vecs[6] = '{16'h0030, 4'd4,  "chord_4_5"};
    seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    kp_if.key_ready = 1'b1;

    // Reset and column scan
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_col", col, 4'b1110);
    check("reset_valid", kp_if.key_valid, 1'b0);
    check("reset_pressed", kp_if.key_pressed, 1'b0);
    reset = 1'b0;
    check("release_col", col, 4'b1110);
    for (int s = 1; s <= 8; s++) begin
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("col_hold", col, seq[(s-1)%4]);
      @(posedge clk);
      @(negedge clk);
      check("col_step", col, seq[s%4]);
    end
    check("scan_valid", kp_if.key_valid, 1'b0);
    check("scan_pressed", kp_if.key_pressed, 1'b0);

    // Table-driven presses
    foreach (vecs[i]) begin
      keys = vecs[i].keys;
      exp_q.push_back(vecs[i].code);
      repeat (160) @(posedge clk);
      @(negedge clk);
      check({vecs[i].name, "_pressed"}, kp_if.key_pressed, 1'b1);
      check({vecs[i].name, "_drained"}, exp_q.size(), 0);
      keys = '0;
      repeat (160) @(posedge clk);
      @(negedge clk);
      check({vecs[i].name, "_released"}, kp_if.key_pressed, 1'b0);
    end

    // Bounce: alternating frames never debounce
    saved = ev_count;
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      repeat (40) @(posedge clk);
    end
    @(negedge clk);
    check("bounce_no_event", ev_count, saved);
    check("bounce_not_pressed", kp_if.key_pressed, 1'b0);
    keys = 16'h0200;
    exp_q.push_back(4'd9);
    repeat (160) @(posedge clk);
    @(negedge clk);
    check("bounce_one_event", ev_count, saved + 1);
    check("bounce_pressed", kp_if.key_pressed, 1'b1);
    keys = '0;
    repeat (160) @(posedge clk);

    // Backpressure: later press is dropped while 3 is pending
    kp_if.key_ready = 1'b0;
    saved = ev_count;
    keys = 16'h0008;
    repeat (160) @(posedge clk);
    keys = '0;
    repeat (160) @(posedge clk);
    keys = 16'h1000;
    repeat (160) @(posedge clk);
    keys = '0;
    repeat (160) @(posedge clk);
    @(negedge clk);
    check("bp_valid_held", kp_if.key_valid, 1'b1);
    check("bp_code_held", kp_if.key_code, 4'd3);
    exp_q.push_back(4'd3);
    @(posedge clk); #1;
    kp_if.key_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bp_valid_cleared", kp_if.key_valid, 1'b0);
    check("bp_one_transfer", ev_count, saved + 1);

    // Reset one clock after the first debounce frame
    wait_frame_end(ok);
    keys = 16'h0200;
    wait_frame_end(ok);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_col", col, 4'b1110);
    check("mid_reset_valid", kp_if.key_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    saved = ev_count;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("mid_reset_no_event", ev_count, saved);
    check("mid_reset_not_pressed", kp_if.key_pressed, 1'b0);
    exp_q.push_back(4'd9);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("mid_reset_event", ev_count, saved + 1);
    check("mid_reset_pressed", kp_if.key_pressed, 1'b1);
    keys = '0;
    repeat (160) @(posedge clk);
    @(negedge clk);

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/thcattus_keypad_scanner.md
Name: thcattus_keypad_scanner

Overview:
- Multiplexed matrix-keypad scanner: the input-side counterpart of the team's multiplexed 7-segment display driver.
- Strobes one column at a time, samples the row lines, debounces over whole scan frames, and delivers one key-press event per press on a valid/ready interface.
- Sits between board keypad pins and control logic; key codes are 4-bit-compatible with the 7-seg display data path at default size.

Parameters:
ROWS, 4, number of row inputs (>=1)
COLS, 4, number of column outputs (>=2)
CLOCK_FREQ, 25_000_000, clk frequency in Hz
SCAN_RATE, 1_000, column switch frequency in Hz; DIV = CLOCK_FREQ/SCAN_RATE clocks per column, DIV>=4
DEBOUNCE_SCANS, 4, consecutive identical frames required to accept a press or a release (>=1)
REPEAT_FRAMES, 64, auto-repeat interval in frames (used only with the optional feature)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
col  output  COLS  column strobes, active-low, exactly one bit low at any time
row  input  ROWS  row returns, active-low (external pull-ups), asynchronous
key_code  output  $clog2(ROWS*COLS)  event code = col_index*ROWS + row_index
key_valid  output  1  event available; held until accepted
key_ready  input  1  consumer accept; transfer when key_valid && key_ready
key_pressed  output  1  debounced "any key held" level

Behaviour:
- Clocking: one clock; reset is asynchronous and active-high. All state resets asynchronously.
- Reset values: col = ~1 (column 0 driven), key_code = 0, key_valid = 0, key_pressed = 0, FSM = IDLE, all counters 0.
- Row sync: row passes through a 2-flop synchronizer (reset to all-ones) before any use.
- Divider: counts 0..DIV-1 and wraps; tick is asserted when count == DIV-1.
- Sampling: synchronized rows are sampled on the tick, i.e. at the end of the column period, after settling. col advances on the same edge; column index wraps COLS-1 -> 0.
- Frame: COLS ticks, ending with the column COLS-1 sample.
- Frame result: the lowest code with its row bit low. Column scanned earlier wins; within a column, the lower row wins. NONE if no row bit is low.
- FSM, evaluated once per frame end:
  - IDLE: result != NONE -> DEB_PRESS; latch cand = result, cnt = 1.
  - DEB_PRESS:
    - result == cand -> cnt+1.
    - On reaching DEBOUNCE_SCANS -> HELD; raise key_pressed and emit event(cand).
    - result != cand -> IDLE (a different key restarts debounce at the next frame).
  - HELD: result == NONE -> DEB_REL with cnt = 1; otherwise stay. A chord change while held emits nothing.
  - DEB_REL:
    - NONE for DEBOUNCE_SCANS frames -> IDLE; clear key_pressed.
    - Any non-NONE result -> HELD.
- With DEBOUNCE_SCANS = 1: a press is emitted at the end of the first frame that shows it, and a release returns to IDLE at the end of the first NONE frame.
- Event emit:
  - key_valid = 0: key_code <= cand and key_valid <= 1 on the next clock.
  - key_valid = 1 (pending): the new event is dropped. key_code and key_valid stay unchanged, so no overwrite occurs.
- Handshake:
  - key_code is stable while key_valid = 1.
  - A transfer clears key_valid on the next clock.
  - If a transfer and an emit fall on the same edge, the emit wins: key_valid stays 1 with the new code.
  - key_ready while key_valid = 0 has no effect.
- Reset mid-frame: the scan restarts at column 0, the FSM returns to IDLE, and any pending event is discarded.

Optional Feature:
THCATTUS_KEYPAD_AUTOREPEAT_EN
- Defined:
  - In HELD, a repeat counter counts frames.
  - Every REPEAT_FRAMES frames it re-emits cand, subject to the same drop rule as a normal emit.
  - The counter is cleared on entry to HELD and on leaving HELD.
- Undefined: exactly one event per press; no repeat counter is synthesized, and REPEAT_FRAMES is ignored.

Decomposition:
- Package thcattus_keypad_pkg:
  - FSM state encoding: IDLE, DEB_PRESS, HELD, DEB_REL.
  - NONE sentinel: an extra "found" flag alongside the code.
  - Code-width function: $clog2(ROWS*COLS).
- Sub-module thcattus_keypad_scan_timer: the DIV divider plus column index/one-hot-low col generator, outputting tick, col_idx and frame_end.
- Debounce FSM and handshake logic stay in the top module.

Test Plan:
Sim parameters for every scenario: CLOCK_FREQ = 1000, SCAN_RATE = 100 (DIV = 10, frame = 40 clk), DEBOUNCE_SCANS = 2, ROWS = COLS = 4, key_ready = 1 unless stated.
- Reset/scan:
  - Release reset -> col = 4'b1110.
  - col steps 1101, 1011, 0111, 1110, one step every 10 clk.
  - key_valid = 0 and key_pressed = 0 throughout.
- Single press: hold the key at column 2, row 1 (row[1] low only while col[2] low) -> after 2 full frames, key_code = 9 with a single key_valid pulse; key_pressed = 1; release for 2 frames -> key_pressed = 0 with no further event.
- Bounce: toggle row[1] every frame for 6 frames, then hold -> no event during the toggling; exactly one event (code 9) after 2 stable frames.
- Chord/priority: hold codes 6 and 13 together -> event code 6 only.
- Backpressure: key_ready = 0; press code 3, release, press code 12 -> key_code stays 3 with key_valid held; raise key_ready -> one transfer of 3, and 12 is lost.
- Reset mid-debounce: assert reset 1 clk after the first frame of a press -> col = 1110, FSM in IDLE, no event until 2 new full frames have passed.
